// File: rtl/ternary_trit_packer.sv
// Quantizes a stream of signed samples to trits and packs them 16 per 32-bit word,
// WORDS words per hypervector, with flush-to-pad and valid/ready on both sides.
module ternary_trit_packer #(
    parameter int IN_W   = 8,
    parameter int THRESH = 0,
    parameter int WORDS  = 64,
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_flush,
    output logic [31:0]            out_word,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    typedef enum logic {
        PACK = 1'b0,
        PAD  = 1'b1
    } state_t;

    localparam logic signed [IN_W:0] TH_POS   = (IN_W+1)'(THRESH);
    localparam logic signed [IN_W:0] TH_NEG   = -TH_POS;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [31:0]          PAD_WORD = 32'h5555_5555;

    // Dead-zone quantizer: 00=-1, 01=0, 10=+1; one extra bit keeps -THRESH representable.
    function automatic logic [1:0] quantize(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] xe;
        xe = {x[IN_W-1], x};
        if (xe > TH_POS) begin
            return 2'b10;
        end
        if (xe < TH_NEG) begin
            return 2'b00;
        end
        return 2'b01;
    endfunction

    function automatic logic [31:0] set_trit(input logic [31:0] w, input logic [3:0] pos,
                                             input logic [1:0] t);
        logic [31:0] r;
        r = w;
        r[{pos, 1'b0} +: 2] = t;
        return r;
    endfunction

    function automatic logic [31:0] pad_from(input logic [31:0] w, input logic [3:0] first);
        logic [31:0] r;
        r = w;
        for (int k = 0; k < 16; k++) begin
            if (k >= int'(first)) begin
                r[2*k +: 2] = 2'b01;
            end
        end
        return r;
    endfunction

    state_t             state_q, state_nxt;
    logic [3:0]         tcnt_q, tcnt_nxt;
    logic [IDX_W-1:0]   widx_q, widx_nxt;
    logic [31:0]        asm_p0, asm_nxt;
    logic [31:0]        word_p1, word_nxt;
    logic [IDX_W-1:0]   idx_p1, idx_nxt;
    logic               last_p1, last_nxt;
    logic               vld_p1, vld_nxt;

    logic               accept;
    logic               out_free;
    logic [31:0]        asm_acc;
    logic [3:0]         tcnt_eff;
    logic [IDX_W-1:0]   widx_eff;

    // The last slot may only fill when the completed word has somewhere to go.
    assign in_ready = (state_q == PACK) && !((tcnt_q == 4'd15) && vld_p1 && !out_ready);
    assign accept   = in_valid && in_ready;
    assign out_free = !vld_p1 || out_ready;

    always_comb begin
        state_nxt = state_q;
        tcnt_nxt  = tcnt_q;
        widx_nxt  = widx_q;
        asm_nxt   = asm_p0;
        word_nxt  = word_p1;
        idx_nxt   = idx_p1;
        last_nxt  = last_p1;
        vld_nxt   = vld_p1;
        asm_acc   = asm_p0;
        tcnt_eff  = tcnt_q;
        widx_eff  = widx_q;

        if (vld_p1 && out_ready) begin
            vld_nxt = 1'b0;
        end

        unique case (state_q)
            PACK: begin
                if (accept) begin
                    asm_acc = set_trit(asm_p0, tcnt_q, quantize(in_data));
                    if (tcnt_q == 4'd15) begin
                        vld_nxt  = 1'b1;
                        word_nxt = asm_acc;
                        idx_nxt  = widx_q;
                        last_nxt = (widx_q == LAST_IDX);
                        tcnt_eff = 4'd0;
                        widx_eff = (widx_q == LAST_IDX) ? '0 : widx_q + 1'b1;
                    end else begin
                        tcnt_eff = tcnt_q + 4'd1;
                    end
                end
                asm_nxt  = asm_acc;
                tcnt_nxt = tcnt_eff;
                widx_nxt = widx_eff;
                // A flush that lands exactly on a vector boundary has nothing left to pad.
                if (in_flush && ((tcnt_eff != 4'd0) || (widx_eff != '0))) begin
                    state_nxt = PAD;
                    asm_nxt   = pad_from(asm_acc, tcnt_eff);
                    tcnt_nxt  = 4'd0;
                end
            end
            PAD: begin
                if (out_free) begin
                    vld_nxt  = 1'b1;
                    word_nxt = asm_p0;
                    idx_nxt  = widx_q;
                    last_nxt = (widx_q == LAST_IDX);
                    asm_nxt  = PAD_WORD;
                    if (widx_q == LAST_IDX) begin
                        state_nxt = PACK;
                        widx_nxt  = '0;
                    end else begin
                        widx_nxt = widx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = PACK;
            end
        endcase
    end

    // Stage p0: trit assembly register
    always_ff @(posedge clk) begin
        asm_p0 <= asm_nxt;
    end

    // Stage p1: control state and output word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PACK;
            tcnt_q  <= '0;
            widx_q  <= '0;
            word_p1 <= '0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tcnt_q  <= tcnt_nxt;
            widx_q  <= widx_nxt;
            word_p1 <= word_nxt;
            idx_p1  <= idx_nxt;
            last_p1 <= last_nxt;
            vld_p1  <= vld_nxt;
        end
    end

    assign out_word  = word_p1;
    assign out_idx   = idx_p1;
    assign out_last  = last_p1;
    assign out_valid = vld_p1;
    assign busy      = (tcnt_q != 4'd0) || (widx_q != '0) || vld_p1 || (state_q == PAD);

endmodule

// File: tb/tb_ternary_trit_packer.sv
// Bench for ternary_trit_packer: directed scenarios plus randomized traffic, with a
// word-level reference model (sample lists -> trit arithmetic) feeding a scoreboard.
module tb_ternary_trit_packer;

    localparam int IN_W  = 8;
    localparam int WORDS = 64;
    localparam int IDX_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid, in_flush, out_ready;
    logic                   in_ready, out_last, out_valid, busy;
    logic [31:0]            out_word;
    logic [IDX_W-1:0]       out_idx;
    logic                   in_ready_t2, out_last_t2, out_valid_t2, busy_t2;
    logic [31:0]            out_word_t2;
    logic [IDX_W-1:0]       out_idx_t2;

    ternary_trit_packer #(.IN_W(IN_W), .THRESH(0), .WORDS(WORDS)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush(in_flush), .out_word(out_word), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    ternary_trit_packer #(.IN_W(IN_W), .THRESH(2), .WORDS(WORDS)) u_dut_t2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_t2),
        .in_flush(in_flush), .out_word(out_word_t2), .out_idx(out_idx_t2), .out_last(out_last_t2),
        .out_valid(out_valid_t2), .out_ready(out_ready), .busy(busy_t2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: raw samples of the current word, word/vector position.
    typedef struct packed {
        logic [31:0]      w0;
        logic [31:0]      w2;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   m_samp[16];
    int   m_cnt  = 0;
    int   m_widx = 0;

    function automatic int trit_of(input int x, input int th);
        if (x > th) return 1;
        if (x < -th) return -1;
        return 0;
    endfunction

    // Trit k contributes (t+1) * 4^k: first sample lands in the lowest two bits.
    function automatic logic [31:0] word_of(input int th);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < 16; k++) begin
            w = w | (32'(trit_of(m_samp[k], th) + 1) << (2 * k));
        end
        return w;
    endfunction

    function automatic void model_word();
        exp_t e;
        e.w0   = word_of(0);
        e.w2   = word_of(2);
        e.idx  = IDX_W'(m_widx);
        e.last = (m_widx == WORDS - 1);
        expq.push_back(e);
        m_widx = (m_widx + 1) % WORDS;
        m_cnt  = 0;
    endfunction

    function automatic void model_accept(input int x);
        m_samp[m_cnt] = x;
        m_cnt++;
        if (m_cnt == 16) model_word();
    endfunction

    function automatic void model_flush();
        if (m_cnt == 0 && m_widx == 0) return;
        do begin
            for (int k = m_cnt; k < 16; k++) m_samp[k] = 0;
            model_word();
        end while (m_widx != 0);
    endfunction

    // Monitor on the falling edge: inputs and outputs are settled, handshakes happen next rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_cnt  = 0;
            m_widx = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_word", 32'(expq.size()), 32'd1);
                end else begin
                    mon_e = expq.pop_front();
                    check("sb_word", out_word, mon_e.w0);
                    check("sb_idx", 32'(out_idx), 32'(mon_e.idx));
                    check("sb_last", 32'(out_last), 32'(mon_e.last));
                    check("sb_vld_t2", 32'(out_valid_t2), 32'd1);
                    check("sb_word_t2", out_word_t2, mon_e.w2);
                    check("sb_idx_t2", 32'(out_idx_t2), 32'(mon_e.idx));
                    check("sb_last_t2", 32'(out_last_t2), 32'(mon_e.last));
                end
            end
            if (in_valid && in_ready) model_accept(int'(in_data));
            if (in_flush) model_flush();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_word", out_word, 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_busy_t2", 32'(busy_t2), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ready_t2", 32'(in_ready_t2), 32'd1);
    endtask

    // Offer one sample and return just after the edge that accepts it.
    task automatic send(input int x);
        int waited;
        bit acc;
        waited   = 0;
        in_data  = IN_W'(x);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 32'(waited), 32'd0);
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n         = 0;
        in_valid  = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        while (expq.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        check(tag, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen62;
        bit fl;

        // T1: 16 x +5 -> AAAAAAAA, valid one cycle after the 16th accept
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(5);
            if (i == 14) check("t1_early_vld", 32'(out_valid), 32'd0);
        end
        check("t1_vld", 32'(out_valid), 32'd1);
        check("t1_word", out_word, 32'hAAAA_AAAA);
        check("t1_idx", 32'(out_idx), 32'd0);
        check("t1_last", 32'(out_last), 32'd0);
        drain("t1_drain");

        // T2: a whole vector of -1, then the next word restarts at idx 0
        do_reset();
        for (int i = 0; i < 16 * WORDS; i++) send(-1);
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 255)) - 128);
        drain("t2_drain");

        // T3: consumer stalled; second word parks at its 16th trit
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 31; i++) send(int'($urandom_range(0, 255)) - 128);
        check("t3_stall_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("t3_hold_vld", 32'(out_valid), 32'd1);
        check("t3_hold_word", out_word, expq[0].w0);
        check("t3_hold_idx", 32'(out_idx), 32'd0);
        check("t3_still_stalled", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(int'($urandom_range(0, 255)) - 128);
        drain("t3_drain");

        // T4: 62 words, then +1,0,-1 and flush pads out the vector
        do_reset();
        for (int i = 0; i < 16 * 62; i++) send(int'($urandom_range(0, 255)) - 128);
        send(1);
        send(0);
        send(-1);
        in_valid = 1'b0;
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        n = 0;
        seen62 = 0;
        while (!(out_valid && out_idx == 6'd63) && n < 20) begin
            check("t4_pad_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_idx == 6'd62) begin
                seen62++;
                check("t4_word62", out_word, 32'h5555_5546);
                check("t4_last62", 32'(out_last), 32'd0);
            end
            tick();
            n++;
        end
        check("t4_seen62", 32'(seen62), 32'd1);
        check("t4_word63", out_word, 32'h5555_5555);
        check("t4_last63", 32'(out_last), 32'd1);
        drain("t4_drain");

        // T5: THRESH=2 instance; THRESH=0 instance sees the same samples
        do_reset();
        send(3);
        send(2);
        send(-2);
        send(-3);
        for (int i = 0; i < 12; i++) send(0);
        check("t5_word_t2", out_word_t2, 32'h5555_5516);
        check("t5_word_t0", out_word, 32'h5555_550A);
        drain("t5_drain");

        // T6: reset mid-word discards the partial word
        do_reset();
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)) - 128);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_vld", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(1);
        check("t6_word", out_word, 32'hAAAA_AAAA);
        check("t6_idx", 32'(out_idx), 32'd0);
        drain("t6_drain");

        // Randomized traffic with backpressure and occasional flushes
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            fl        = ($urandom_range(0, 149) == 0);
            in_flush  = fl;
            tick();
            in_flush = 1'b0;
            if (fl) begin
                in_valid = 1'b0;
                n = 0;
                while (expq.size() != 0 && n < 2000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                    n++;
                end
                check("rnd_flush_drain", 32'(expq.size()), 32'd0);
            end
        end
        drain("rnd_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
